// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcodes, condition codes, flag bit positions and
// the fetch-unit state encoding.
package cpu_defs;

  localparam int unsigned CPU_ADDR_W  = 16;
  localparam int unsigned CPU_DATA_W  = 32;
  localparam int unsigned CPU_FLAGS_W = 4;
  localparam int unsigned FETCH_ST_W  = 3;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_LDI  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [3:0] COND_AL = 4'd0;
  localparam logic [3:0] COND_EQ = 4'd1;
  localparam logic [3:0] COND_NE = 4'd2;
  localparam logic [3:0] COND_CS = 4'd3;
  localparam logic [3:0] COND_CC = 4'd4;
  localparam logic [3:0] COND_MI = 4'd5;
  localparam logic [3:0] COND_PL = 4'd6;
  localparam logic [3:0] COND_VS = 4'd7;
  localparam logic [3:0] COND_VC = 4'd8;

  // Flags arrive packed as {N,Z,C,V}
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [FETCH_ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [FETCH_ST_W-1:0] ST_FETCH  = 3'd1;
  localparam logic [FETCH_ST_W-1:0] ST_WAIT   = 3'd2;
  localparam logic [FETCH_ST_W-1:0] ST_DECODE = 3'd3;
  localparam logic [FETCH_ST_W-1:0] ST_ISSUE  = 3'd4;
  localparam logic [FETCH_ST_W-1:0] ST_HALT   = 3'd5;

endpackage

// File: rtl/instr_fetch_unit_cond_check.sv
// Condition-code evaluator: decides whether an instruction executes given
// its condition field and the current ALU flags. Codes 9..15 never execute.
module cond_check
  import cpu_defs::*;
(
  input  logic [3:0]             condition,
  input  logic [CPU_FLAGS_W-1:0] flags,
  output logic                   pass_c
);

  always_comb begin
    pass_c = 1'b0;
    case (condition)
      COND_AL: pass_c = 1'b1;
      COND_EQ: pass_c = flags[FLAG_Z];
      COND_NE: pass_c = ~flags[FLAG_Z];
      COND_CS: pass_c = flags[FLAG_C];
      COND_CC: pass_c = ~flags[FLAG_C];
      COND_MI: pass_c = flags[FLAG_N];
      COND_PL: pass_c = ~flags[FLAG_N];
      COND_VS: pass_c = flags[FLAG_V];
      COND_VC: pass_c = ~flags[FLAG_V];
      default: pass_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/decode front end: owns the PC, reads program RAM into the instruction
// register, filters on condition code and issues over a valid/ready handshake.
module instr_fetch_unit
  import cpu_defs::*;
#(
  parameter int unsigned       ADDR_W      = CPU_ADDR_W,
  parameter int unsigned       DATA_W      = CPU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]        HALT_OPCODE = OP_HALT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_W-1:0]      mem_data_out,
  output logic                   mem_enable,
  output logic                   mem_read_write,
  output logic [ADDR_W-1:0]      mem_address,
  input  logic [CPU_FLAGS_W-1:0] flags,
  input  logic                   instr_ready,
  input  logic                   pc_load,
  input  logic [ADDR_W-1:0]      pc_load_value,
  output logic                   instr_valid,
  output logic [DATA_W-1:0]      instruction,
  output logic [3:0]             condition,
  output logic [3:0]             op_code,
  output logic                   s_bit,
  output logic [3:0]             destination,
  output logic [3:0]             source_2_sel,
  output logic [3:0]             source_1_sel,
  output logic [15:0]            immediate_value,
  output logic [ADDR_W-1:0]      PC_out,
  output logic                   halted
);

  logic [FETCH_ST_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]     ir_q, ir_d;
  logic                  mem_enable_q, instr_valid_q, halted_q;
  logic                  cond_pass;

  cond_check u_cond_check (
    .condition (ir_q[31:28]),
    .flags     (flags),
    .pass_c    (cond_pass)
  );

  // Next-state, PC and IR update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        ir_d    = mem_data_out;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (ir_q[27:24] == HALT_OPCODE) begin
          state_d = ST_HALT;
        end else if (!cond_pass) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (instr_ready) begin
          pc_d    = pc_load ? pc_load_value : pc_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered state; strobes are decoded from the next state so they align with it
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      mem_enable_q  <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      mem_enable_q  <= (state_d == ST_FETCH);
      instr_valid_q <= (state_d == ST_ISSUE);
      halted_q      <= (state_d == ST_HALT);
    end
  end

  assign mem_enable      = mem_enable_q;
  assign mem_read_write  = 1'b1;
  assign mem_address     = pc_q;
  assign instr_valid     = instr_valid_q;
  assign halted          = halted_q;
  assign PC_out          = pc_q;
  assign instruction     = ir_q;
  assign condition       = ir_q[31:28];
  assign op_code         = ir_q[27:24];
  assign s_bit           = ir_q[23];
  assign destination     = ir_q[22:19];
  assign source_2_sel    = ir_q[18:15];
  assign source_1_sel    = ir_q[14:11];
  assign immediate_value = ir_q[18:3];

endmodule
